// File: rtl/rr_grant_collector.sv
// Captures the word and source ID of whichever requester the round-robin arbiter grants.
// Entries go through a first-word-fall-through FIFO. Also tracks multi-hot grant errors and overflow drops.
module rr_grant_collector #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      GNT,
   input  logic [4*DW-1:0] DIN,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [DW-1:0]   OUT_DATA,
   output logic [1:0]      OUT_SRC,
   output logic            FULL,
   output logic            EMPTY,
   output logic [AW:0]     COUNT,
   output logic [7:0]      DROP_CNT,
   output logic            ERR
);

   logic [DW-1:0] r_mem_data [DEPTH];
   logic [1:0]    r_mem_src  [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [7:0]    r_drop_cnt;
   logic          r_err;

   logic          w_onehot;
   logic          w_multi;
   logic [1:0]    w_idx;
   logic [DW-1:0] w_din;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;

   // GNT & (GNT-1) clears the lowest set bit; if the result is zero, GNT had exactly one bit set.
   assign w_onehot = (GNT != 4'b0000) && ((GNT & (GNT - 4'd1)) == 4'b0000);
   assign w_multi  = (GNT != 4'b0000) && !w_onehot;

   always_comb begin
      w_idx = 2'd0;
      w_din = '0;
      for (int i = 0; i < 4; i++) begin
         if (GNT[i]) begin
            w_idx = 2'(i);
            w_din = DIN[i*DW +: DW];
         end
      end
   end

   assign w_full  = (r_count == (AW+1)'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = !w_empty && OUT_READY;
   // When full, a push is still accepted if a pop frees a slot in the same cycle.
   assign w_push  = w_onehot && (!w_full || w_pop);
   assign w_drop  = w_onehot && !w_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_drop_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
         if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
         if (w_multi) r_err <= 1'b1;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr_ptr] <= w_din;
         r_mem_src[r_wr_ptr]  <= w_idx;
      end
   end

   assign OUT_VALID = !w_empty;
   assign OUT_DATA  = w_empty ? '0 : r_mem_data[r_rd_ptr];
   assign OUT_SRC   = w_empty ? 2'd0 : r_mem_src[r_rd_ptr];
   assign FULL      = w_full;
   assign EMPTY     = w_empty;
   assign COUNT     = r_count;
   assign DROP_CNT  = r_drop_cnt;
   assign ERR       = r_err;

endmodule
